// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared state encoding and default timeout for the Wishbone master engine
package wb_master_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;
    localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: saturating count of ack-less bus cycles, flags the last allowed cycle
module wb_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    // clear wins over count; saturate at LIMIT so the count can never wrap
    always_comb begin
        cnt_d = clr ? '0 : (en && cnt_q != W'(LIMIT)) ? cnt_q + W'(1) : cnt_q;
    end
    // counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    // this cycle's increment would reach LIMIT, so the bus cycle must end now
    assign expired = cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/wb_master_engine.sv
// wb_master_engine: single-outstanding command/response bridge onto a classic Wishbone master
module wb_master_engine import wb_master_pkg::*; #(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int ADDR_W         = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_adr,
    input  logic [31:0]       cmd_dat,
    input  logic [3:0]        cmd_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_dat,
    output logic              rsp_err,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic              wbm_ack_i,
    input  logic [31:0]       wbm_dat_i,
    output logic              busy
);
    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       rsp_dat_q, rsp_dat_d;
    logic              rsp_err_q, rsp_err_d;
    logic              expired;
    logic              accept;
    logic              done;

    assign accept = state_q == ST_IDLE && cmd_valid;
    assign done   = state_q == ST_BUS && (wbm_ack_i || expired);

    wb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (state_q != ST_BUS),
        .en     (state_q == ST_BUS && !wbm_ack_i),
        .expired(expired)
    );

    // state register; reset abandons any bus cycle in flight without a response
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // next-state: ack and timeout both leave BUS, the consumer releases RESP
    always_comb begin
        state_d = state_q == ST_IDLE ? (cmd_valid ? ST_BUS : ST_IDLE)
                : state_q == ST_BUS  ? (done ? ST_RESP : ST_BUS)
                : (rsp_ready ? ST_IDLE : ST_RESP);
    end

    // state-decoded outputs; cmd_ready is also held low during reset
    always_comb begin
        cmd_ready = state_q == ST_IDLE && !wb_rst_i;
        wbm_cyc_o = state_q == ST_BUS;
        wbm_stb_o = state_q == ST_BUS;
        rsp_valid = state_q == ST_RESP;
        busy      = state_q != ST_IDLE;
    end

    // command fields load on acceptance; response captured on ack (ack beats timeout)
    always_comb begin
        we_d      = accept ? cmd_we  : we_q;
        adr_d     = accept ? cmd_adr : adr_q;
        dat_d     = accept ? cmd_dat : dat_q;
        sel_d     = accept ? cmd_sel : sel_q;
        rsp_dat_d = !done ? rsp_dat_q : (wbm_ack_i && !we_q) ? wbm_dat_i : 32'h0;
        rsp_err_d = done ? !wbm_ack_i : rsp_err_q;
    end

    // datapath registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_wb_master_engine.sv
// tb_wb_master_engine: directed vector table plus reset/idle-ack sequences for wb_master_engine
module tb_wb_master_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_master_engine #(.TIMEOUT_CYCLES(255), .ADDR_W(32)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i),
        .wbm_dat_i(wbm_dat_i),
        .busy     (busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ack_at;
        logic [31:0] ack_dat;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_n;
        int          hold;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // caller is positioned at a negedge with the engine idle
    task automatic run_txn(input vec_t v);
        int n;
        chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_we = v.we;
        cmd_adr = v.adr;
        cmd_dat = v.dat;
        cmd_sel = v.sel;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cyc_bus", {31'b0, wbm_cyc_o}, 32'd1);
        chk("stb_bus", {31'b0, wbm_stb_o}, 32'd1);
        chk("we_bus", {31'b0, wbm_we_o}, {31'b0, v.we});
        chk("adr_bus", wbm_adr_o, v.adr);
        chk("dat_bus", wbm_dat_o, v.dat);
        chk("sel_bus", {28'b0, wbm_sel_o}, {28'b0, v.sel});
        chk("cmd_ready_bus", {31'b0, cmd_ready}, 32'd0);
        n = 0;
        while (wbm_cyc_o === 1'b1 && n < 300) begin
            wbm_ack_i = (n == v.ack_at);
            wbm_dat_i = v.ack_dat;
            @(negedge clk);
            n++;
        end
        wbm_ack_i = 1'b0;
        chk("bus_cycles", n, v.exp_n);
        chk("stb_drop", {31'b0, wbm_stb_o}, 32'd0);
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_dat", rsp_dat, v.exp_dat);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
        chk("busy_resp", {31'b0, busy}, 32'd1);
        for (int i = 0; i < v.hold; i++) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = 32'h5555_AAAA;
            @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_dat", rsp_dat, v.exp_dat);
            chk("hold_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
            chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            chk("hold_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        end
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        chk("busy_idle", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 3,   32'hDEAD_BEEF, 32'h0,         1'b0, 4,   0};
        vecs[1] = '{1'b0, 32'h3800_0000, 32'h0,         4'hF, 0,   32'h1234_5678, 32'h1234_5678, 1'b0, 1,   0};
        vecs[2] = '{1'b0, 32'h1000_0010, 32'h0,         4'h3, 999, 32'hFFFF_FFFF, 32'h0,         1'b1, 255, 0};
        vecs[3] = '{1'b0, 32'h2000_0020, 32'h0,         4'hC, 254, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 255, 0};
        vecs[4] = '{1'b0, 32'h4000_0000, 32'h0,         4'h1, 1,   32'h0BAD_1DEA, 32'h0BAD_1DEA, 1'b0, 2,   10};
        vecs[5] = '{1'b1, 32'h5000_0008, 32'h7777_0000, 4'h8, 999, 32'h1111_2222, 32'h0,         1'b1, 255, 3};

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
        chk("rst_we", {31'b0, wbm_we_o}, 32'd0);
        chk("rst_sel", {28'b0, wbm_sel_o}, 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // ack while idle must be ignored
        @(negedge clk);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h9999_9999;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        chk("idle_ack_busy", {31'b0, busy}, 32'd0);
        chk("idle_ack_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("idle_ack_rsp_dat", rsp_dat, 32'd0);

        for (int k = 0; k < 6; k++) run_txn(vecs[k]);

        // reset pulsed mid-BUS abandons the cycle
        cmd_valid = 1'b1;
        cmd_we = 1'b0;
        cmd_adr = 32'h6000_0000;
        cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_cyc", {31'b0, wbm_cyc_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk("midrst_stb", {31'b0, wbm_stb_o}, 32'd0);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("after_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        run_txn(vecs[1]);
        run_txn(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
